// File: rtl/pipe_trace_capture_if.sv
// Trace capture bundle: per-stage sample inputs plus the valid/ready drain port.
// out_stamp is present only when TRACE_TIMESTAMP_EN is defined.
interface pipe_trace_capture_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 64
);
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH-1:0]        out_mask;
  logic [NUM_CH*DATA_W-1:0] out_data;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]              out_stamp;

  modport master (
    output ch_valid, ch_data, out_ready,
    input  out_valid, out_mask, out_data, out_stamp
  );
  modport slave (
    input  ch_valid, ch_data, out_ready,
    output out_valid, out_mask, out_data, out_stamp
  );
`else
  modport master (
    output ch_valid, ch_data, out_ready,
    input  out_valid, out_mask, out_data
  );
  modport slave (
    input  ch_valid, ch_data, out_ready,
    output out_valid, out_mask, out_data
  );
`endif
endinterface

// File: rtl/pipe_trace_capture.sv
// Multi-channel pipeline trace recorder: settle window, masked capture into a FIFO, drop/limit tracking.
// Optional macro TRACE_TIMESTAMP_EN adds a per-entry 32-bit capture-cycle stamp (out_stamp).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_SETTLE | post-reset settle window, counting up to SETTLE_CYCLES
// S_ARMED  | capturing one record per cycle with any channel valid
// S_DONE   | record limit reached; capture stopped, drain continues
module pipe_trace_capture #(
  parameter int NUM_CH        = 2,
  parameter int DATA_W        = 64,
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 3,
  parameter int MAX_RECORDS   = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  pipe_trace_capture_if.slave    tr,
  output logic                   armed,
  output logic                   done,
  output logic [15:0]            drop_cnt,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PAY_W = NUM_CH * DATA_W;
  localparam int REC_W = NUM_CH + PAY_W;
  localparam logic [31:0]      SETTLE_LAST = (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;
  localparam logic [31:0]      REC_LIMIT   = 32'(MAX_RECORDS);
  localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(DEPTH);

  typedef enum logic [1:0] {S_SETTLE, S_ARMED, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      settle_q, settle_d;
  logic [31:0]      rec_cnt_q, rec_cnt_d;
  logic [15:0]      drop_q, drop_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PAY_W-1:0] rec_pay;
  logic [REC_W-1:0] rec;
  logic             rec_vld, full, head_vld, push, pop, drop;

  // Invalid channels are zeroed so stale stage payloads never leak into the trace.
  always_comb begin
    rec_pay = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tr.ch_valid[i]) rec_pay[i*DATA_W +: DATA_W] = tr.ch_data[i*DATA_W +: DATA_W];
    end
  end

  assign rec      = {tr.ch_valid, rec_pay};
  assign rec_vld  = (state_q == S_ARMED) && (tr.ch_valid != '0);
  assign full     = (level_q == LVL_FULL);
  assign head_vld = (level_q != '0);
  assign pop      = head_vld && tr.out_ready;
  assign push     = rec_vld && (!full || pop);
  assign drop     = rec_vld && full && !pop;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      S_SETTLE: begin
        settle_d = settle_q + 32'd1;
        if (settle_q >= SETTLE_LAST) state_d = S_ARMED;
      end
      S_ARMED: begin
        if ((MAX_RECORDS > 0) && rec_vld && (rec_cnt_d == REC_LIMIT)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_SETTLE;
    endcase
  end

  always_comb begin
    rec_cnt_d = rec_cnt_q;
    drop_d    = drop_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    level_d   = level_q;
    if (rec_vld) rec_cnt_d = rec_cnt_q + 32'd1;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    if (push) wr_d = wr_q + PTR_W'(1);
    if (pop)  rd_d = rd_q + PTR_W'(1);
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_SETTLE;
      settle_q  <= '0;
      rec_cnt_q <= '0;
      drop_q    <= '0;
      level_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      rec_cnt_q <= rec_cnt_d;
      drop_q    <= drop_d;
      level_q   <= level_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
    end
  end

  // Storage needs no reset: the head is only exposed while level is non-zero.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= rec;
  end

  assign tr.out_valid               = head_vld;
  assign {tr.out_mask, tr.out_data} = head_vld ? mem_q[rd_q] : '0;
  assign armed                      = (state_q == S_ARMED);
  assign done                       = (state_q == S_DONE);
  assign drop_cnt                   = drop_q;
  assign level                      = level_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] stamp_q, stamp_d;
  logic [31:0] smem_q [DEPTH];

  always_comb begin
    stamp_d = stamp_q;
    if (state_q == S_ARMED) stamp_d = stamp_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stamp_q <= '0;
    else        stamp_q <= stamp_d;
  end

  always_ff @(posedge clock) begin
    if (push) smem_q[wr_q] <= stamp_q;
  end

  assign tr.out_stamp = head_vld ? smem_q[rd_q] : '0;
`endif
endmodule

// File: tb/tb_pipe_trace_capture.sv
// Bench for pipe_trace_capture: two instances (DEPTH=4 unlimited, DEPTH=16 limit 5) checked against a queue model.
module tb_pipe_trace_capture;
  localparam int NCH    = 2;
  localparam int DW     = 64;
  localparam int PW     = NCH * DW;
  localparam int SETTLE = 3;

  typedef struct packed {
    logic [NCH-1:0] m;
    logic [PW-1:0]  d;
    logic [31:0]    s;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCH-1:0] vin;
  logic [PW-1:0]  din;
  logic           armed_a, done_a, armed_b, done_b;
  logic [15:0]    drop_a, drop_b;
  logic [2:0]     lvl_a;
  logic [4:0]     lvl_b;

  pipe_trace_capture_if #(.NUM_CH(NCH), .DATA_W(DW)) ifa ();
  pipe_trace_capture_if #(.NUM_CH(NCH), .DATA_W(DW)) ifb ();

  assign ifa.ch_valid = vin;
  assign ifa.ch_data  = din;
  assign ifb.ch_valid = vin;
  assign ifb.ch_data  = din;

  pipe_trace_capture #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(4), .SETTLE_CYCLES(3), .MAX_RECORDS(0)) u_a (
    .clock(clk), .reset(rst_n), .tr(ifa),
    .armed(armed_a), .done(done_a), .drop_cnt(drop_a), .level(lvl_a)
  );
  pipe_trace_capture #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(16), .SETTLE_CYCLES(3), .MAX_RECORDS(5)) u_b (
    .clock(clk), .reset(rst_n), .tr(ifb),
    .armed(armed_b), .done(done_b), .drop_cnt(drop_b), .level(lvl_b)
  );

  int   vectors    = 0;
  int   miscompares = 0;
  rec_t qa[$];
  rec_t qb[$];
  int   sc[2];
  int   recs[2];
  int   drops[2];
  bit   dn[2];
  logic [31:0] ts[2];

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 16;
  endfunction
  function automatic int maxr(input int k);
    return (k == 0) ? 0 : 5;
  endfunction
  function automatic int qsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction
  function automatic bit exp_armed(input int k);
    return !dn[k] && (sc[k] >= SETTLE);
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sc[k] = 0; recs[k] = 0; drops[k] = 0; dn[k] = 1'b0; ts[k] = '0;
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic model_edge();
    bit   arm, rdy, pop, full;
    rec_t r;
    for (int k = 0; k < 2; k++) begin
      arm  = exp_armed(k);
      rdy  = (k == 0) ? ifa.out_ready : ifb.out_ready;
      pop  = (qsize(k) > 0) && rdy;
      full = (qsize(k) == dep(k));
      if (pop) begin
        if (k == 0) qa.delete(0); else qb.delete(0);
      end
      if (arm && (vin != '0)) begin
        r.m = vin;
        r.d = '0;
        r.s = ts[k];
        for (int c = 0; c < NCH; c++)
          if (vin[c]) r.d[c*DW +: DW] = din[c*DW +: DW];
        if (!full || pop) begin
          if (k == 0) qa.push_back(r); else qb.push_back(r);
        end else if (drops[k] < 65535) begin
          drops[k]++;
        end
        recs[k]++;
        if ((maxr(k) > 0) && (recs[k] == maxr(k))) dn[k] = 1'b1;
      end
      if (arm) ts[k] = ts[k] + 32'd1;
      if (sc[k] < 1000) sc[k]++;
    end
  endtask

  task automatic check_all();
    rec_t ha, hb;
    ha = '0;
    hb = '0;
    if (qa.size() > 0) ha = qa[0];
    if (qb.size() > 0) hb = qb[0];
    chk("a_valid", 160'(ifa.out_valid), 160'(qa.size() > 0));
    chk("a_mask",  160'(ifa.out_mask),  160'(ha.m));
    chk("a_data",  160'(ifa.out_data),  160'(ha.d));
    chk("a_level", 160'(lvl_a),         160'(qa.size()));
    chk("a_drop",  160'(drop_a),        160'(drops[0]));
    chk("a_armed", 160'(armed_a),       160'(exp_armed(0)));
    chk("a_done",  160'(done_a),        160'(dn[0]));
    chk("b_valid", 160'(ifb.out_valid), 160'(qb.size() > 0));
    chk("b_mask",  160'(ifb.out_mask),  160'(hb.m));
    chk("b_data",  160'(ifb.out_data),  160'(hb.d));
    chk("b_level", 160'(lvl_b),         160'(qb.size()));
    chk("b_drop",  160'(drop_b),        160'(drops[1]));
    chk("b_armed", 160'(armed_b),       160'(exp_armed(1)));
    chk("b_done",  160'(done_b),        160'(dn[1]));
`ifdef TRACE_TIMESTAMP_EN
    chk("a_stamp", 160'(ifa.out_stamp), 160'(ha.s));
    chk("b_stamp", 160'(ifb.out_stamp), 160'(hb.s));
`endif
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic step(input bit do_chk);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    if (do_chk) check_all();
    @(negedge clk);
  endtask

  task automatic rnd_data();
    din = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  initial begin
    rst_n = 1'b1;
    vin = '0;
    din = '0;
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_a_data", 160'(ifa.out_data), 160'(0));

    // Settle window with both channels valid throughout.
    rst_n = 1'b1;
    vin = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rnd_data();
      step(1'b1);
    end
    chk("settle_armed_3clk", 160'(armed_a), 160'(1));
    rnd_data();
    step(1'b1);
    chk("first_entry_level", 160'(lvl_a), 160'(1));
    chk("first_entry_mask", 160'(ifa.out_mask), 160'(2'b11));
`ifdef TRACE_TIMESTAMP_EN
    chk("first_entry_stamp", 160'(ifa.out_stamp), 160'(0));
`endif
    // Five more valid cycles: A overflows, B hits its record limit.
    for (int i = 0; i < 5; i++) begin
      rnd_data();
      step(1'b1);
    end
    chk("ovf_level", 160'(lvl_a), 160'(4));
    chk("ovf_drop", 160'(drop_a), 160'(2));
    chk("limit_done", 160'(done_b), 160'(1));
    chk("limit_armed", 160'(armed_b), 160'(0));
    chk("limit_level", 160'(lvl_b), 160'(5));

    // Full with simultaneous pop: push accepted.
    ifa.out_ready = 1'b1;
    rnd_data();
    step(1'b1);
    chk("fullpop_level", 160'(lvl_a), 160'(4));
    chk("fullpop_drop", 160'(drop_a), 160'(2));

    // Drain both in order.
    vin = '0;
    ifb.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1);
    chk("drain_b_valid", 160'(ifb.out_valid), 160'(0));
    chk("drain_b_done", 160'(done_b), 160'(1));
    chk("drain_a_level", 160'(lvl_a), 160'(0));

    // Masking and zeroing of an invalid channel.
    ifa.out_ready = 1'b0;
    ifb.out_ready = 1'b0;
    vin = 2'b01;
    din = {64'hDEAD_BEEF_0000_0001, 64'h0100_0000_0000_0013};
    step(1'b1);
    chk("mask_01", 160'(ifa.out_mask), 160'(2'b01));
    chk("mask_hi_zero", 160'(ifa.out_data[127:64]), 160'(0));
    chk("mask_lo_data", 160'(ifa.out_data[63:0]), 160'(64'h0100_0000_0000_0013));
    vin = '0;
    for (int i = 0; i < 3; i++) begin
      rnd_data();
      step(1'b1);
    end
    chk("idle_level", 160'(lvl_a), 160'(1));

    // Push and pop together on empty: the push lands.
    ifa.out_ready = 1'b1;
    step(1'b1);
    vin = 2'b10;
    rnd_data();
    step(1'b1);
    chk("emptypp_valid", 160'(ifa.out_valid), 160'(1));
    chk("emptypp_level", 160'(lvl_a), 160'(1));

    // Randomized traffic: first mostly stalled, then mostly draining.
    for (int i = 0; i < 400; i++) begin
      vin = NCH'($urandom_range(0, 3));
      rnd_data();
      ifa.out_ready = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ifb.out_ready = ($urandom_range(0, 1) == 0);
      step(1'b1);
    end

    // Drop counter saturation.
    ifa.out_ready = 1'b0;
    vin = 2'b11;
    for (int i = 0; i < 65600; i++) step(1'b0);
    step(1'b1);
    chk("drop_sat", 160'(drop_a), 160'(16'hFFFF));

    // Async reset between edges at level 3.
    vin = '0;
    ifa.out_ready = 1'b1;
    step(1'b1);
    chk("pre_rst_level", 160'(lvl_a), 160'(3));
    ifa.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 160'(ifa.out_valid), 160'(0));
    chk("rst_level", 160'(lvl_a), 160'(0));
    chk("rst_drop", 160'(drop_a), 160'(0));
    chk("rst_done_b", 160'(done_b), 160'(0));
    check_all();
    #1 rst_n = 1'b1;
    vin = 2'b11;
    for (int i = 0; i < 3; i++) begin
      rnd_data();
      step(1'b1);
    end
    chk("resettle_armed", 160'(armed_a), 160'(1));
    rnd_data();
    step(1'b1);
    chk("resettle_level", 160'(lvl_a), 160'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
